// File: rtl/bringup_exerciser_if.sv
// Pad bundle between the FABulous IO wrapper and the bring-up exerciser.
// master = wrapper/board side, slave = exerciser side.
interface bringup_exerciser_if;
    logic [30:0] io_in;
    logic [30:0] io_out;
    logic [30:0] io_oeb;

    modport master (output io_in, input io_out, input io_oeb);
    modport slave  (input io_in, output io_out, output io_oeb);
endinterface

// File: rtl/bringup_exerciser.sv
// Fabric bring-up exerciser: drives a selectable 8-bit pattern, checks the
// looped-back copy, counts mismatches and reports the count over UART TX.
module bringup_exerciser #(
    parameter int unsigned STEP_DIV = 4,
    parameter int unsigned BAUD_DIV = 8,
    parameter int unsigned HB_BIT   = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    bringup_exerciser_if.slave io
);

    typedef enum logic [1:0] {
        MODE_CNT    = 2'd0,
        MODE_WALK   = 2'd1,
        MODE_LFSR   = 2'd2,
        MODE_MIRROR = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    localparam logic [15:0] STEP_LAST = 16'(STEP_DIV - 1);
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

    // Sync vector layout: {req, clr, cap[7:0], mode[1:0]}
    logic [11:0] sync1_q, sync1_d, sync2_q, sync2_d;
    mode_e       mode_s, mode_prev_q, mode_prev_d;
    logic [7:0]  cap_s;
    logic        clr_s, req_s;

    logic [15:0] presc_q, presc_d;
    logic        tick;
    logic [7:0]  pat_q, pat_d, pat_next;
    logic        armed_q, armed_d;
    logic [7:0]  err_q, err_d;
    logic        err_flag_q, err_flag_d;
    logic [23:0] hb_q, hb_d;
    logic        req_prev_q, req_prev_d;
    logic        mode_chg, req_rise;

    tx_state_e   tx_state_q;
    logic [15:0] baud_q;
    logic [2:0]  bit_q;
    logic [7:0]  tx_byte_q;
    logic        tx_q;
    logic        baud_last;

    logic        unused_in;

    assign sync1_d = {io.io_in[23:22], io.io_in[20:13], io.io_in[1:0]};
    assign sync2_d = sync1_q;
    assign mode_s  = mode_e'(sync2_q[1:0]);
    assign cap_s   = sync2_q[9:2];
    assign clr_s   = sync2_q[10];
    assign req_s   = sync2_q[11];

    assign unused_in = ^{io.io_in[30:24], io.io_in[21], io.io_in[12:2]};

    assign tick      = (presc_q == STEP_LAST);
    assign mode_chg  = (mode_s != mode_prev_q);
    assign req_rise  = req_s & ~req_prev_q;
    assign baud_last = (baud_q == BAUD_LAST);

    always_comb begin
        case (mode_s)
            MODE_CNT:  pat_next = pat_q + 8'd1;
            MODE_WALK: pat_next = {pat_q[6:0], pat_q[7]};
            MODE_LFSR: pat_next = {pat_q[6:0], pat_q[7] ^ pat_q[5] ^ pat_q[4] ^ pat_q[3]};
            default:   pat_next = cap_s;
        endcase
    end

    always_comb begin
        presc_d     = tick ? '0 : presc_q + 16'd1;
        pat_d       = pat_q;
        armed_d     = armed_q;
        err_d       = err_q;
        mode_prev_d = mode_s;
        req_prev_d  = req_s;
        hb_d        = hb_q + 24'd1;

        if (mode_chg) begin
            // Reseed cycle: no step and no compare, the next tick only re-arms.
            presc_d = '0;
            armed_d = 1'b0;
            case (mode_s)
                MODE_CNT:    pat_d = 8'h00;
                MODE_MIRROR: pat_d = cap_s;
                default:     pat_d = 8'h01;
            endcase
        end else if (mode_s == MODE_MIRROR) begin
            pat_d = cap_s;
        end else if (tick) begin
            pat_d = pat_next;
            if (!armed_q) begin
                armed_d = 1'b1;
            end else if ((cap_s != pat_q) && (err_q != 8'hFF)) begin
                err_d = err_q + 8'd1;
            end
        end

        if (clr_s) begin
            err_d = '0;
        end
        err_flag_d = |err_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            mode_prev_q <= MODE_CNT;
            presc_q     <= '0;
            pat_q       <= '0;
            armed_q     <= 1'b0;
            err_q       <= '0;
            err_flag_q  <= 1'b0;
            hb_q        <= '0;
            req_prev_q  <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            mode_prev_q <= mode_prev_d;
            presc_q     <= presc_d;
            pat_q       <= pat_d;
            armed_q     <= armed_d;
            err_q       <= err_d;
            err_flag_q  <= err_flag_d;
            hb_q        <= hb_d;
            req_prev_q  <= req_prev_d;
        end
    end

    // 8N1 transmitter; tx_byte_q shifts right so bit 0 is always the next data bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            tx_byte_q  <= '0;
            tx_q       <= 1'b1;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    tx_q   <= 1'b1;
                    baud_q <= '0;
                    if (req_rise) begin
                        tx_byte_q  <= err_q;
                        tx_q       <= 1'b0;
                        tx_state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (baud_last) begin
                        baud_q     <= '0;
                        bit_q      <= '0;
                        tx_q       <= tx_byte_q[0];
                        tx_byte_q  <= {1'b0, tx_byte_q[7:1]};
                        tx_state_q <= TX_DATA;
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                TX_DATA: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            tx_q       <= 1'b1;
                            tx_state_q <= TX_STOP;
                        end else begin
                            bit_q     <= bit_q + 3'd1;
                            tx_q      <= tx_byte_q[0];
                            tx_byte_q <= {1'b0, tx_byte_q[7:1]};
                        end
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                default: begin
                    if (baud_last) begin
                        baud_q     <= '0;
                        tx_state_q <= TX_IDLE;
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        io.io_out        = '0;
        io.io_out[3]     = tx_q;
        io.io_out[4]     = hb_q[HB_BIT];
        io.io_out[12:5]  = pat_q;
        io.io_out[21]    = err_flag_q;
    end

    assign io.io_oeb = 31'h7FDF_E007;

endmodule

// File: tb/tb_bringup_exerciser.sv
// Directed bench for bringup_exerciser: pattern scoreboard plus error count
// observed only through the UART report pin.
module tb_bringup_exerciser;

    localparam int unsigned STEP = 4;
    localparam int unsigned BAUD = 8;
    localparam int unsigned HB   = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode_pin;
    logic        clr_pin, req_pin;
    logic        force_en;
    logic [7:0]  force_val, lb_mask;
    logic [7:0]  cap_bus;
    logic [7:0]  pat_o;
    logic        tx_o, hb_o, flag_o;

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  exp_q[$];

    always #5 clk = ~clk;

    bringup_exerciser_if bus();

    assign cap_bus    = force_en ? force_val : (bus.io_out[12:5] & lb_mask);
    assign bus.io_in  = {7'b0, req_pin, clr_pin, 1'b0, cap_bus, 11'b0, mode_pin};
    assign pat_o      = bus.io_out[12:5];
    assign tx_o       = bus.io_out[3];
    assign hb_o       = bus.io_out[4];
    assign flag_o     = bus.io_out[21];

    bringup_exerciser #(
        .STEP_DIV(STEP),
        .BAUD_DIV(BAUD),
        .HB_BIT  (HB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .io   (bus)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    task automatic wait_change(input string tag);
        logic [7:0] prev;
        int n;
        prev = pat_o;
        n = 0;
        while (pat_o === prev && n < 4 * STEP) begin
            cyc(1);
            n++;
        end
        check(tag, 32'(pat_o !== prev), 32'd1);
    endtask

    // Pulses req and decodes one frame, sampling mid-bit; strict adds exact
    // latency, bit-edge checks, a mid-frame second pulse and idle-after checks.
    task automatic read_uart(input string tag, input logic [7:0] exp, input bit strict);
        logic [7:0] got;
        logic       eb;
        int         n;
        got = '0;
        req_pin = 1'b1;
        n = 0;
        while (tx_o !== 1'b0 && n < 20) begin
            cyc(1);
            n++;
        end
        if (strict) check({tag, "_latency"}, 32'(n), 32'd3);
        else        check({tag, "_start"}, 32'(n < 20), 32'd1);
        req_pin = 1'b0;
        for (int s = 0; s < 10; s++) begin
            if (s == 0)      eb = 1'b0;
            else if (s == 9) eb = 1'b1;
            else             eb = exp[s-1];
            if (strict) check($sformatf("%s_b%0d_first", tag, s), 32'(tx_o), 32'(eb));
            if (strict && s == 3) req_pin = 1'b1;
            if (strict && s == 6) req_pin = 1'b0;
            cyc(3);
            if (s >= 1 && s <= 8) got[s-1] = tx_o;
            else check($sformatf("%s_frame%0d", tag, s), 32'(tx_o), 32'(eb));
            cyc(4);
            if (strict) check($sformatf("%s_b%0d_last", tag, s), 32'(tx_o), 32'(eb));
            cyc(1);
        end
        check(tag, 32'(got), 32'(exp));
        if (strict) begin
            n = 0;
            for (int i = 0; i < 3 * BAUD; i++) begin
                if (tx_o !== 1'b1) n++;
                cyc(1);
            end
            check({tag, "_no_requeue"}, 32'(n), 32'd0);
        end
        cyc(2);
    endtask

    initial begin
        logic [7:0] v;
        int         errs;
        int         n;
        logic       prev_hb;

        mode_pin  = 2'd0;
        clr_pin   = 1'b0;
        req_pin   = 1'b0;
        force_en  = 1'b0;
        force_val = 8'h00;
        lb_mask   = 8'hFF;
        rst_n     = 1'b0;
        cyc(3);
        check("rst_io_out", 32'(bus.io_out), 32'h0000_0008);
        check("rst_oeb", 32'(bus.io_oeb), 32'h7FDF_E007);
        rst_n = 1'b1;

        // Counter with perfect loopback
        for (int i = 0; i < 64; i++) exp_q.push_back(8'(i));
        check("cnt_pat0", 32'(pat_o), 32'(exp_q.pop_front()));
        for (int i = 1; i < 64; i++) begin
            wait_change("cnt_step");
            check($sformatf("cnt_pat%0d", i), 32'(pat_o), 32'(exp_q.pop_front()));
        end
        check("cnt_flag", 32'(flag_o), 32'd0);
        mode_pin = 2'd3;
        cyc(3);
        read_uart("cnt_err", 8'h00, 1'b0);

        // Heartbeat period is 2*2^HB clocks, half-period 2^HB
        prev_hb = hb_o;
        n = 0;
        while (hb_o === prev_hb && n < 40) begin cyc(1); n++; end
        prev_hb = hb_o;
        n = 0;
        while (hb_o === prev_hb && n < 40) begin cyc(1); n++; end
        check("hb_half_period", 32'(n), 32'(1 << HB));

        // LFSR with io_in[13] stuck at 0
        lb_mask = 8'hFE;
        v = 8'h01;
        errs = 0;
        exp_q.push_back(v);
        for (int i = 1; i <= 255; i++) begin
            v = lfsr_next(v);
            exp_q.push_back(v);
            if (i <= 254 && v[0]) errs++;
        end
        mode_pin = 2'd2;
        cyc(3);
        check("lfsr_seed", 32'(pat_o), 32'(exp_q.pop_front()));
        for (int i = 1; i <= 255; i++) begin
            wait_change("lfsr_step");
            check($sformatf("lfsr_pat%0d", i), 32'(pat_o), 32'(exp_q.pop_front()));
        end
        mode_pin = 2'd3;
        cyc(3);
        check("lfsr_flag", 32'(flag_o), 32'd1);
        read_uart("lfsr_err", 8'(errs), 1'b0);

        // Saturation with bus forced to 0
        lb_mask   = 8'hFF;
        force_en  = 1'b1;
        force_val = 8'h00;
        mode_pin  = 2'd1;
        cyc(3);
        check("walk_seed", 32'(pat_o), 32'h01);
        cyc(300 * STEP);
        mode_pin = 2'd3;
        cyc(3);
        check("sat_flag", 32'(flag_o), 32'd1);
        read_uart("sat_err", 8'hFF, 1'b0);
        mode_pin = 2'd1;
        cyc(3 + 20 * STEP);
        mode_pin = 2'd3;
        cyc(3);
        read_uart("sat_hold", 8'hFF, 1'b0);

        // Error clear
        clr_pin = 1'b1;
        cyc(1);
        clr_pin = 1'b0;
        cyc(1);
        check("clr_flag_before", 32'(flag_o), 32'd1);
        cyc(1);
        check("clr_flag_after", 32'(flag_o), 32'd0);
        read_uart("clr_err", 8'h00, 1'b0);

        // Clear held while mismatches occur
        clr_pin  = 1'b1;
        mode_pin = 2'd1;
        cyc(3 + 20 * STEP);
        mode_pin = 2'd3;
        cyc(3);
        check("clr_wins_flag", 32'(flag_o), 32'd0);
        clr_pin = 1'b0;
        cyc(3);
        read_uart("clr_wins", 8'h00, 1'b0);

        // Mode switch mid-run
        force_en = 1'b0;
        mode_pin = 2'd0;
        cyc(3);
        n = 0;
        while (pat_o !== 8'h23 && n < 400) begin cyc(1); n++; end
        check("reach_23", 32'(pat_o), 32'h23);
        mode_pin  = 2'd1;
        force_en  = 1'b1;
        force_val = 8'h00;
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h04);
        cyc(2);
        check("sw_hold", 32'(pat_o), 32'h23);
        cyc(1);
        check("sw_seed", 32'(pat_o), 32'(exp_q.pop_front()));
        cyc(STEP - 1);
        check("sw_space1", 32'(pat_o), 32'h01);
        cyc(1);
        check("sw_step1", 32'(pat_o), 32'(exp_q.pop_front()));
        cyc(STEP - 1);
        check("sw_space2", 32'(pat_o), 32'h02);
        cyc(1);
        check("sw_step2", 32'(pat_o), 32'(exp_q.pop_front()));
        mode_pin = 2'd3;
        cyc(3);
        read_uart("sw_err", 8'h01, 1'b0);

        // Build err_cnt = 0xA5: 166 walking-one ticks, first one uncompared
        clr_pin = 1'b1;
        cyc(1);
        clr_pin = 1'b0;
        cyc(3);
        mode_pin = 2'd1;
        cyc(3);
        for (int i = 0; i < 166; i++) wait_change("a5_step");
        mode_pin = 2'd3;
        cyc(3);
        check("a5_flag", 32'(flag_o), 32'd1);
        read_uart("report", 8'hA5, 1'b1);
        read_uart("report2", 8'hA5, 1'b0);

        // Mirror mode, then reset mid-frame
        force_val = 8'h5A;
        cyc(2);
        check("mirror_early", 32'(pat_o), 32'h00);
        cyc(1);
        check("mirror_3clk", 32'(pat_o), 32'h5A);
        req_pin = 1'b1;
        cyc(4);
        req_pin = 1'b0;
        check("mid_frame_low", 32'(tx_o), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_tx", 32'(tx_o), 32'd1);
        check("rst_pat", 32'(pat_o), 32'h00);
        check("rst_oeb_mid", 32'(bus.io_oeb), 32'h7FDF_E007);
        check("rst_io_out_mid", 32'(bus.io_out), 32'h0000_0008);
        cyc(2);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 12 * BAUD; i++) begin
            if (tx_o !== 1'b1) n++;
            cyc(1);
        end
        check("no_resume", 32'(n), 32'd0);
        check("mirror_after_rst", 32'(pat_o), 32'h5A);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
